// File: rtl/fft_power_peak_pkg.sv
// Shared types and constants for the FFT power/peak stage (package fft_pkg).
package fft_pkg;

    localparam int FFT_POINTS_DEFAULT = 8192;

    typedef enum logic {
        IDLE,
        IN_FRAME
    } frame_state_t;

    // re^2 + im^2 of two signed IN_W values always fits in 2*IN_W unsigned bits.
    function automatic int pwr_width(input int in_w);
        return 2 * in_w;
    endfunction

endpackage

// File: rtl/fft_power_peak_mag_sq.sv
// Two-stage squared-magnitude pipeline (module fft_mag_sq) with sop/eop/bin/valid sideband.
module fft_mag_sq #(
    parameter int IN_W  = 12,
    parameter int BIN_W = 13,
    parameter int PWR_W = 24
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic                    in_sop,
    input  logic                    in_eop,
    input  logic [BIN_W-1:0]        in_bin,
    input  logic signed [IN_W-1:0]  in_real,
    input  logic signed [IN_W-1:0]  in_imag,
    output logic                    out_valid,
    output logic                    out_sop,
    output logic                    out_eop,
    output logic [BIN_W-1:0]        out_bin,
    output logic [PWR_W-1:0]        out_data
);

    // A signed square is non-negative and at most 2^(2*IN_W-2), so its sign bit is dropped.
    function automatic logic [2*IN_W-2:0] square(input logic signed [IN_W-1:0] x);
        logic signed [2*IN_W-1:0] p;
        p = x * x;
        return p[2*IN_W-2:0];
    endfunction

    logic                vld_p1;
    logic                sop_p1;
    logic                eop_p1;
    logic [BIN_W-1:0]    bin_p1;
    logic [2*IN_W-2:0]   re_sq_p1;
    logic [2*IN_W-2:0]   im_sq_p1;

    // Stage 1: squares
    always_ff @(posedge clk) begin
        if (rst) vld_p1 <= 1'b0;
        else     vld_p1 <= in_valid;
        sop_p1   <= in_sop;
        eop_p1   <= in_eop;
        bin_p1   <= in_bin;
        re_sq_p1 <= square(in_real);
        im_sq_p1 <= square(in_imag);
    end

    // Stage 2: sum; outputs clear on reset so the stream reads all-zero afterwards
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_sop   <= 1'b0;
            out_eop   <= 1'b0;
            out_bin   <= '0;
            out_data  <= '0;
        end else begin
            out_valid <= vld_p1;
            out_sop   <= vld_p1 & sop_p1;
            out_eop   <= vld_p1 & eop_p1;
            if (vld_p1) begin
                out_bin  <= bin_p1;
                out_data <= PWR_W'(re_sq_p1) + PWR_W'(im_sq_p1);
            end
        end
    end

endmodule

// File: rtl/fft_power_peak.sv
// Per-bin power stream, per-frame peak search and source framing checks.
// Optional macro FFT_POWER_PEAK_DC_SKIP_EN excludes bin 0 from the peak search.
module fft_power_peak
    import fft_pkg::*;
#(
    parameter int FFT_POINTS = FFT_POINTS_DEFAULT,
    parameter int IN_W       = 12,
    parameter int BIN_W      = $clog2(FFT_POINTS),
    parameter int PWR_W      = pwr_width(IN_W)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    src_valid,
    input  logic                    src_sop,
    input  logic                    src_eop,
    input  logic signed [IN_W-1:0]  src_real,
    input  logic signed [IN_W-1:0]  src_imag,
    output logic                    src_ready,
    output logic                    pwr_valid,
    output logic                    pwr_sop,
    output logic                    pwr_eop,
    output logic [BIN_W-1:0]        pwr_bin,
    output logic [PWR_W-1:0]        pwr_data,
    output logic                    peak_valid,
    output logic [BIN_W-1:0]        peak_bin,
    output logic [PWR_W-1:0]        peak_pwr,
    output logic                    frame_err
);

    localparam logic [BIN_W-1:0] LAST = BIN_W'(FFT_POINTS - 1);

    frame_state_t      state, state_nxt;
    logic [BIN_W-1:0]  cnt, cnt_nxt;
    logic              acc, acc_sop, acc_eop, err;
    logic [BIN_W-1:0]  acc_bin;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            frame_err <= 1'b0;
            src_ready <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            frame_err <= err;
            src_ready <= 1'b1;
        end
    end

    // A sop beat always starts a fresh frame; eop is only good on the last bin.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        acc       = 1'b0;
        acc_sop   = 1'b0;
        acc_eop   = 1'b0;
        acc_bin   = cnt;
        err       = 1'b0;
        if (src_valid) begin
            if (src_sop) begin
                acc     = 1'b1;
                acc_sop = 1'b1;
                acc_bin = '0;
                err     = (state == IN_FRAME);
                if (src_eop) begin
                    err       = 1'b1;
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    state_nxt = IN_FRAME;
                    cnt_nxt   = BIN_W'(1);
                end
            end else if (state == IDLE) begin
                err = 1'b1;
            end else begin
                acc = 1'b1;
                if (src_eop || cnt == LAST) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    if (src_eop && cnt == LAST) acc_eop = 1'b1;
                    else                        err     = 1'b1;
                end else begin
                    cnt_nxt = cnt + BIN_W'(1);
                end
            end
        end
    end

    fft_mag_sq #(
        .IN_W  (IN_W),
        .BIN_W (BIN_W),
        .PWR_W (PWR_W)
    ) u_mag_sq (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (acc),
        .in_sop    (acc_sop),
        .in_eop    (acc_eop),
        .in_bin    (acc_bin),
        .in_real   (src_real),
        .in_imag   (src_imag),
        .out_valid (pwr_valid),
        .out_sop   (pwr_sop),
        .out_eop   (pwr_eop),
        .out_bin   (pwr_bin),
        .out_data  (pwr_data)
    );

    logic [PWR_W-1:0]  max_pwr, max_pwr_nxt;
    logic [BIN_W-1:0]  max_bin, max_bin_nxt;
    logic              load;

    // Strictly-greater update keeps the lowest bin on ties.
    always_comb begin
        load = 1'b0;
`ifdef FFT_POWER_PEAK_DC_SKIP_EN
        if (pwr_bin == BIN_W'(1))
            load = 1'b1;
        else if (pwr_bin != '0 && pwr_data > max_pwr)
            load = 1'b1;
`else
        if (pwr_sop || pwr_data > max_pwr)
            load = 1'b1;
`endif
        max_pwr_nxt = load ? pwr_data : max_pwr;
        max_bin_nxt = load ? pwr_bin  : max_bin;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            max_pwr    <= '0;
            max_bin    <= '0;
            peak_pwr   <= '0;
            peak_bin   <= '0;
            peak_valid <= 1'b0;
        end else begin
            peak_valid <= pwr_valid & pwr_eop;
            if (pwr_valid) begin
                max_pwr <= max_pwr_nxt;
                max_bin <= max_bin_nxt;
            end
            if (pwr_valid && pwr_eop) begin
                peak_pwr <= max_pwr_nxt;
                peak_bin <= max_bin_nxt;
            end
        end
    end

endmodule

// File: tb/tb_fft_power_peak.sv
// Directed bench for fft_power_peak at FFT_POINTS=8, IN_W=12.
module tb_fft_power_peak;

    localparam int N     = 8;
    localparam int IN_W  = 12;
    localparam int BIN_W = 3;
    localparam int PWR_W = 24;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   src_valid, src_sop, src_eop;
    logic signed [IN_W-1:0] src_real, src_imag;
    logic                   src_ready;
    logic                   pwr_valid, pwr_sop, pwr_eop;
    logic [BIN_W-1:0]       pwr_bin;
    logic [PWR_W-1:0]       pwr_data;
    logic                   peak_valid;
    logic [BIN_W-1:0]       peak_bin;
    logic [PWR_W-1:0]       peak_pwr;
    logic                   frame_err;

    fft_power_peak #(.FFT_POINTS(N), .IN_W(IN_W)) dut (
        .clk(clk), .rst(rst),
        .src_valid(src_valid), .src_sop(src_sop), .src_eop(src_eop),
        .src_real(src_real), .src_imag(src_imag), .src_ready(src_ready),
        .pwr_valid(pwr_valid), .pwr_sop(pwr_sop), .pwr_eop(pwr_eop),
        .pwr_bin(pwr_bin), .pwr_data(pwr_data),
        .peak_valid(peak_valid), .peak_bin(peak_bin), .peak_pwr(peak_pwr),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int cyc; int bin; int data; bit sop; bit eop; } pbeat_t;
    typedef struct { int cyc; int bin; int pwr; } peak_t;
    pbeat_t pq[$];
    peak_t  kq[$];
    int     eq[$];
    pbeat_t pb;
    peak_t  pk;

    always @(negedge clk) begin
        if (pwr_valid) begin
            pb.cyc = cyc; pb.bin = int'(pwr_bin); pb.data = int'(pwr_data);
            pb.sop = pwr_sop; pb.eop = pwr_eop;
            pq.push_back(pb);
        end
        if (peak_valid) begin
            pk.cyc = cyc; pk.bin = int'(peak_bin); pk.pwr = int'(peak_pwr);
            kq.push_back(pk);
        end
        if (frame_err) eq.push_back(cyc);
    end

    int checks = 0;
    int passes = 0;
    int fre[N], fim[N], fst[N];
    int stamp;
    int exp_bin, exp_pwr;

    task automatic drive(input bit v, input bit s, input bit e, input int re, input int im);
        src_valid = v; src_sop = s; src_eop = e;
        src_real = IN_W'(re); src_imag = IN_W'(im);
        stamp = cyc;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0);
    endtask

    task automatic send_frame();
        for (int i = 0; i < N; i++) begin
            drive(1, i == 0, i == N - 1, fre[i], fim[i]);
            fst[i] = stamp;
        end
    endtask

    task automatic clear_q();
        pq.delete(); kq.delete(); eq.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        checks++;
        if ({src_ready, pwr_valid, pwr_sop, pwr_eop, peak_valid, frame_err} !== 6'b0) $display("FAIL reset_ctrl got %b want 000000", {src_ready, pwr_valid, pwr_sop, pwr_eop, peak_valid, frame_err});
        else passes++;
        checks++;
        if ({pwr_bin, pwr_data, peak_bin, peak_pwr} !== '0) $display("FAIL reset_data got %h want 0", {pwr_bin, pwr_data, peak_bin, peak_pwr});
        else passes++;
        rst = 1'b0;
        drive(0, 0, 0, 0, 0);
        checks++;
        if (src_ready !== 1'b1) $display("FAIL ready_after_reset got %b want 1", src_ready);
        else passes++;
    endtask

    task automatic test_ramp();
        clear_q();
        for (int i = 0; i < N; i++) begin fre[i] = i; fim[i] = 0; end
        send_frame();
        idle(5);
        checks++;
        if (pq.size() != N) $display("FAIL ramp_count got %0d want %0d", pq.size(), N);
        else passes++;
        for (int i = 0; i < N && i < pq.size(); i++) begin
            checks++;
            if (pq[i].data != i * i || pq[i].bin != i || pq[i].cyc != fst[i] + 2 || pq[i].sop != (i == 0) || pq[i].eop != (i == N - 1))
                $display("FAIL ramp_beat%0d got d=%0d b=%0d lat=%0d s=%0d e=%0d want d=%0d b=%0d lat=2", i, pq[i].data, pq[i].bin, pq[i].cyc - fst[i], pq[i].sop, pq[i].eop, i * i, i);
            else passes++;
        end
        checks++;
        if (kq.size() != 1) $display("FAIL ramp_peak_count got %0d want 1", kq.size());
        else if (kq[0].bin != 7 || kq[0].pwr != 49 || kq[0].cyc != fst[N-1] + 3)
            $display("FAIL ramp_peak got b=%0d p=%0d lat=%0d want b=7 p=49 lat=3", kq[0].bin, kq[0].pwr, kq[0].cyc - fst[N-1]);
        else passes++;
        checks++;
        if (eq.size() != 0) $display("FAIL ramp_err got %0d want 0", eq.size());
        else passes++;
        checks++;
        if (peak_bin !== 3'd7 || peak_pwr !== 24'd49) $display("FAIL ramp_hold got b=%0d p=%0d want b=7 p=49", peak_bin, peak_pwr);
        else passes++;
        exp_bin = 7; exp_pwr = 49;
    endtask

    task automatic test_max_neg();
        clear_q();
        for (int i = 0; i < N; i++) begin fre[i] = 0; fim[i] = 0; end
        fre[3] = -2048; fim[3] = -2048;
        send_frame();
        idle(5);
        checks++;
        if (pq.size() != N) $display("FAIL maxneg_count got %0d want %0d", pq.size(), N);
        else if (pq[3].data != 8388608) $display("FAIL maxneg_pwr got %0d want 8388608", pq[3].data);
        else passes++;
        checks++;
        if (kq.size() != 1) $display("FAIL maxneg_peak_count got %0d want 1", kq.size());
        else if (kq[0].bin != 3 || kq[0].pwr != 8388608) $display("FAIL maxneg_peak got b=%0d p=%0d want b=3 p=8388608", kq[0].bin, kq[0].pwr);
        else passes++;
        exp_bin = 3; exp_pwr = 8388608;
    endtask

    task automatic test_tie();
        int ebin, epwr;
        for (int f = 0; f < 2; f++) begin
            clear_q();
            fre = '{0, 3, 10, 4, 5, 10, 6, 1};
            fim = '{0, 0, 0, 0, 0, 0, 0, 0};
            ebin = 2; epwr = 100;
            if (f == 1) begin
                fre[0] = 30; fim[0] = 10;
`ifndef FFT_POWER_PEAK_DC_SKIP_EN
                ebin = 0; epwr = 1000;
`endif
            end
            send_frame();
            idle(5);
            checks++;
            if (kq.size() != 1) $display("FAIL tie%0d_peak_count got %0d want 1", f, kq.size());
            else if (kq[0].bin != ebin || kq[0].pwr != epwr) $display("FAIL tie%0d_peak got b=%0d p=%0d want b=%0d p=%0d", f, kq[0].bin, kq[0].pwr, ebin, epwr);
            else passes++;
            checks++;
            if (pq.size() != N) $display("FAIL tie%0d_count got %0d want %0d", f, pq.size(), N);
            else if (pq[0].data != (f == 1 ? 1000 : 0)) $display("FAIL tie%0d_bin0 got %0d want %0d", f, pq[0].data, f == 1 ? 1000 : 0);
            else passes++;
            exp_bin = ebin; exp_pwr = epwr;
        end
    endtask

    task automatic test_early_eop();
        clear_q();
        for (int i = 0; i < 6; i++) begin
            drive(1, i == 0, i == 5, 20, 0);
            fst[i] = stamp;
        end
        idle(5);
        checks++;
        if (eq.size() != 1) $display("FAIL early_err_count got %0d want 1", eq.size());
        else if (eq[0] != fst[5] + 1) $display("FAIL early_err_lat got %0d want 1", eq[0] - fst[5]);
        else passes++;
        checks++;
        if (kq.size() != 0) $display("FAIL early_peak got %0d pulses want 0", kq.size());
        else passes++;
        checks++;
        if (int'(peak_bin) != exp_bin || int'(peak_pwr) != exp_pwr) $display("FAIL early_hold got b=%0d p=%0d want b=%0d p=%0d", peak_bin, peak_pwr, exp_bin, exp_pwr);
        else passes++;
        checks++;
        if (pq.size() != 6 || pq[5].eop != 1'b0) $display("FAIL early_beats got %0d want 6 without eop", pq.size());
        else passes++;
        clear_q();
        for (int i = 0; i < N; i++) begin fre[i] = 0; fim[i] = i; end
        send_frame();
        idle(5);
        checks++;
        if (kq.size() != 1) $display("FAIL early_next_count got %0d want 1", kq.size());
        else if (kq[0].bin != 7 || kq[0].pwr != 49) $display("FAIL early_next_peak got b=%0d p=%0d want b=7 p=49", kq[0].bin, kq[0].pwr);
        else passes++;
        exp_bin = 7; exp_pwr = 49;
    endtask

    task automatic test_no_sop();
        int drop_st, sop2_st;
        clear_q();
        drive(1, 0, 0, 40, 0);
        drop_st = stamp;
        idle(3);
        checks++;
        if (eq.size() != 1 || pq.size() != 0) $display("FAIL drop got err=%0d beats=%0d want err=1 beats=0", eq.size(), pq.size());
        else if (eq[0] != drop_st + 1) $display("FAIL drop_err_lat got %0d want 1", eq[0] - drop_st);
        else passes++;
        clear_q();
        for (int i = 0; i < 4; i++) drive(1, i == 0, 0, 20, 0);
        for (int i = 0; i < N; i++) begin
            drive(1, i == 0, i == N - 1, i + 1, 0);
            fst[i] = stamp;
        end
        sop2_st = fst[0];
        idle(5);
        checks++;
        if (eq.size() != 1 || eq[0] != sop2_st + 1) $display("FAIL sop2_err got n=%0d want 1 at lat 1", eq.size());
        else passes++;
        checks++;
        if (pq.size() != 12) $display("FAIL sop2_beats got %0d want 12", pq.size());
        else if (pq[4].bin != 0 || pq[4].sop != 1'b1 || pq[11].bin != 7 || pq[11].eop != 1'b1)
            $display("FAIL sop2_restart got b4=%0d s4=%0d b11=%0d e11=%0d want 0 1 7 1", pq[4].bin, pq[4].sop, pq[11].bin, pq[11].eop);
        else passes++;
        checks++;
        if (kq.size() != 1) $display("FAIL sop2_peak_count got %0d want 1", kq.size());
        else if (kq[0].bin != 7 || kq[0].pwr != 64 || kq[0].cyc != fst[N-1] + 3)
            $display("FAIL sop2_peak got b=%0d p=%0d want b=7 p=64", kq[0].bin, kq[0].pwr);
        else passes++;
    endtask

    task automatic test_back_to_back();
        int e1, e2, r, late;
        clear_q();
        for (int i = 0; i < N; i++) begin fre[i] = i; fim[i] = 0; end
        send_frame();
        e1 = fst[N-1];
        for (int i = 0; i < N; i++) fre[i] = 7 - i;
        send_frame();
        e2 = fst[N-1];
        for (int i = 0; i < 3; i++) drive(1, i == 0, 0, 5, 5);
        rst = 1'b1;
        drive(0, 0, 0, 0, 0);
        r = stamp;
        checks++;
        if ({src_ready, pwr_valid, peak_valid, frame_err} !== 4'b0 || {pwr_data, peak_bin, peak_pwr} !== '0)
            $display("FAIL midrst_outputs got rdy=%b pv=%b kv=%b pk=%0d want all 0", src_ready, pwr_valid, peak_valid, peak_pwr);
        else passes++;
        drive(0, 0, 0, 0, 0);
        rst = 1'b0;
        idle(6);
        checks++;
        if (kq.size() != 2) $display("FAIL b2b_peak_count got %0d want 2", kq.size());
        else if (kq[0].cyc != e1 + 3 || kq[0].bin != 7 || kq[1].cyc != e2 + 3 || kq[1].bin != 0 || kq[1].pwr != 49)
            $display("FAIL b2b_peaks got b0=%0d b1=%0d p1=%0d want 7 0 49", kq[0].bin, kq[1].bin, kq[1].pwr);
        else passes++;
        late = 0;
        foreach (pq[i]) if (pq[i].cyc > r) late++;
        foreach (kq[i]) if (kq[i].cyc > r) late++;
        checks++;
        if (late != 0 || pq.size() != 18) $display("FAIL midrst_flush got late=%0d beats=%0d want late=0 beats=18", late, pq.size());
        else passes++;
        checks++;
        if (src_ready !== 1'b1 || {pwr_valid, peak_valid, frame_err} !== 3'b0 || {peak_bin, peak_pwr} !== '0)
            $display("FAIL post_rst got rdy=%b pv=%b kv=%b err=%b pk=%0d want 1 0 0 0 0", src_ready, pwr_valid, peak_valid, frame_err, peak_pwr);
        else passes++;
    endtask

    initial begin
        rst = 1'b1;
        src_valid = 1'b0; src_sop = 1'b0; src_eop = 1'b0;
        src_real = '0; src_imag = '0;
        test_reset();
        test_ramp();
        test_max_neg();
        test_tie();
        test_early_eop();
        test_no_sop();
        test_back_to_back();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
